keypad_emulator: RTL and testbench



---
 rtl/keypad_emulator.sv | 160 ++++++++++++++++
 tb/tb_keypad_emulator.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_emulator.sv
// keypad_emulator: responder side of a 4x4 matrix-keypad scan.
// Accepts key-press requests over valid/ready. It then pulls the column of
// the requested key low whenever the scanner drives that key's row, with
// LFSR-driven contact bounce at press and at release.
module keypad_emulator #(
  parameter int unsigned HOLD_CYCLES   = 2000000,
  parameter int unsigned GAP_CYCLES    = 500000,
  parameter int unsigned BOUNCE_CYCLES = 20000,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       key_ready,
  input  logic [3:0] LINE,
  output logic [3:0] COLLUMMN,
  output logic       busy,
  output logic       key_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BOUNCE_IN,
    S_HOLD,
    S_BOUNCE_OUT,
    S_GAP
  } state_t;

  localparam logic        BOUNCE_EN   = (BOUNCE_CYCLES != 0);
  localparam logic [31:0] HOLD_LAST   = 32'(HOLD_CYCLES - 1);
  localparam logic [31:0] GAP_LAST    = 32'(GAP_CYCLES - 1);
  localparam logic [31:0] BOUNCE_LAST = 32'(BOUNCE_CYCLES - 1);

  state_t      r_state;
  logic [31:0] r_cnt;
  logic [7:0]  r_lfsr;
  logic        r_contact;
  logic [1:0]  r_row;
  logic [1:0]  r_col;
  logic        r_done;

  logic [7:0]  w_lfsr_next;
  logic [3:0]  w_pos;
  logic        w_idle;

  // Keyword -> {row, col} of the physical key position
  function automatic logic [3:0] key_pos(input logic [3:0] code);
    key_pos = '0;
    case (code)
      4'd1:  key_pos = {2'd0, 2'd0};
      4'd2:  key_pos = {2'd0, 2'd1};
      4'd3:  key_pos = {2'd0, 2'd2};
      4'd10: key_pos = {2'd0, 2'd3};
      4'd4:  key_pos = {2'd1, 2'd0};
      4'd5:  key_pos = {2'd1, 2'd1};
      4'd6:  key_pos = {2'd1, 2'd2};
      4'd11: key_pos = {2'd1, 2'd3};
      4'd7:  key_pos = {2'd2, 2'd0};
      4'd8:  key_pos = {2'd2, 2'd1};
      4'd9:  key_pos = {2'd2, 2'd2};
      4'd12: key_pos = {2'd2, 2'd3};
      4'd14: key_pos = {2'd3, 2'd0};
      4'd0:  key_pos = {2'd3, 2'd1};
      4'd15: key_pos = {2'd3, 2'd2};
      4'd13: key_pos = {2'd3, 2'd3};
      default: key_pos = '0;
    endcase
  endfunction

  assign w_pos       = key_pos(key_code);
  // Fibonacci LFSR, taps 8,6,5,4
  assign w_lfsr_next = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  assign w_idle      = (r_state == S_IDLE);
  assign key_ready   = w_idle;
  assign busy        = ~w_idle;
  assign key_done    = r_done;

  // Press sequencer: state, dwell counter, bounce LFSR and registered contact
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_lfsr    <= LFSR_SEED;
      r_contact <= 1'b0;
      r_row     <= '0;
      r_col     <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_cnt  <= r_cnt + 32'd1;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (key_valid) begin
            {r_row, r_col} <= w_pos;
            if (BOUNCE_EN) begin
              r_state   <= S_BOUNCE_IN;
              r_contact <= r_lfsr[0];
            end else begin
              r_state   <= S_HOLD;
              r_contact <= 1'b1;
            end
          end
        end
        S_BOUNCE_IN: begin
          // contact tracks the LFSR bit of the cycle it is visible in
          r_lfsr <= w_lfsr_next;
          if (r_cnt == BOUNCE_LAST) begin
            r_state   <= S_HOLD;
            r_cnt     <= '0;
            r_contact <= 1'b1;
          end else begin
            r_contact <= w_lfsr_next[0];
          end
        end
        S_HOLD: begin
          if (r_cnt == HOLD_LAST) begin
            r_cnt <= '0;
            if (BOUNCE_EN) begin
              r_state   <= S_BOUNCE_OUT;
              r_contact <= r_lfsr[0];
            end else begin
              r_state   <= S_GAP;
              r_contact <= 1'b0;
            end
          end
        end
        S_BOUNCE_OUT: begin
          r_lfsr <= w_lfsr_next;
          if (r_cnt == BOUNCE_LAST) begin
            r_state   <= S_GAP;
            r_cnt     <= '0;
            r_contact <= 1'b0;
          end else begin
            r_contact <= w_lfsr_next[0];
          end
        end
        S_GAP: begin
          if (r_cnt == GAP_LAST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_contact <= 1'b0;
        end
      endcase
    end
  end

  // Switch path: column follows the row drive with no register in between
  always_comb begin
    COLLUMMN = '1;
    if (r_contact && !LINE[r_row]) COLLUMMN[r_col] = 1'b0;
  end

endmodule

// File: tb/tb_keypad_emulator.sv
// Bench for keypad_emulator: two instances (no bounce / 6-cycle bounce)
// share stimulus; a reference model queues the expected per-cycle contact
// timeline for each, and a negedge monitor pops and compares.
module tb_keypad_emulator;

  localparam int unsigned HOLD = 8;
  localparam int unsigned GAP  = 4;
  localparam int unsigned BA   = 0;
  localparam int unsigned BB   = 6;
  localparam logic [7:0]  SEED = 8'hA5;

  typedef struct packed {
    logic       contact;
    logic [1:0] row;
    logic [1:0] col;
    logic       done;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       key_valid;
  logic [3:0] key_code;
  logic [3:0] LINE;
  logic [3:0] col_a, col_b;
  logic       ready_a, ready_b, busy_a, busy_b, done_a, done_b;

  int n_checks = 0;
  int n_errors = 0;

  exp_t       qa[$];
  exp_t       qb[$];
  int         m_rem [2] = '{0, 0};
  logic [7:0] m_lfsr[2] = '{SEED, SEED};

  // Key map written out from the keypad layout, indexed by keyword
  int MAP_ROW[16] = '{3, 0, 0, 0, 1, 1, 1, 2, 2, 2, 0, 1, 2, 3, 3, 3};
  int MAP_COL[16] = '{1, 0, 1, 2, 0, 1, 2, 0, 1, 2, 3, 3, 3, 3, 0, 2};

  keypad_emulator #(
    .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .BOUNCE_CYCLES(BA), .LFSR_SEED(SEED)
  ) dut_a (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .key_ready(ready_a), .LINE(LINE), .COLLUMMN(col_a), .busy(busy_a),
    .key_done(done_a)
  );

  keypad_emulator #(
    .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .BOUNCE_CYCLES(BB), .LFSR_SEED(SEED)
  ) dut_b (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .key_ready(ready_b), .LINE(LINE), .COLLUMMN(col_b), .busy(busy_b),
    .key_done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  task automatic chk(input string name, input int inst, input logic [3:0] act,
                     input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s dut%0d: got %b expected %b at %0t", name, inst, act, exp, $time);
    end
  endtask

  task automatic push(input int i, input exp_t e);
    if (i == 0) qa.push_back(e);
    else        qb.push_back(e);
  endtask

  // Whole press timeline: bounce-in, hold, bounce-out, gap, then done cycle
  task automatic model_accept(input int i, input logic [3:0] code);
    exp_t        e;
    int unsigned b;
    logic [7:0]  l;
    b = (i == 0) ? BA : BB;
    l = m_lfsr[i];
    e.row  = 2'(MAP_ROW[code]);
    e.col  = 2'(MAP_COL[code]);
    e.done = 1'b0;
    for (int unsigned k = 0; k < b; k++) begin e.contact = l[0]; push(i, e); l = lfsr_step(l); end
    e.contact = 1'b1;
    for (int unsigned k = 0; k < HOLD; k++) push(i, e);
    for (int unsigned k = 0; k < b; k++) begin e.contact = l[0]; push(i, e); l = lfsr_step(l); end
    e.contact = 1'b0;
    for (int unsigned k = 0; k < GAP; k++) push(i, e);
    e.done = 1'b1;
    push(i, e);
    m_lfsr[i] = l;
    m_rem[i]  = int'(2 * b + HOLD + GAP);
  endtask

  // Reference model: decides per instance whether a request is taken
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        if (m_rem[i] == 0) begin
          if (key_valid) model_accept(i, key_code);
        end else begin
          m_rem[i]--;
        end
      end
    end
  end

  task automatic mon(input int i, input logic [3:0] col, input logic bsy,
                     input logic rdy, input logic dn);
    exp_t       e;
    logic [3:0] ec;
    bit         have;
    have = (i == 0) ? (qa.size() != 0) : (qb.size() != 0);
    if (!have) begin
      chk("idle_col", i, col, 4'hF);
      chk("idle_flags", i, {1'b0, bsy, rdy, dn}, 4'b0010);
    end else begin
      if (i == 0) e = qa.pop_front();
      else        e = qb.pop_front();
      ec = 4'hF;
      if (e.contact && LINE[e.row] == 1'b0) ec[e.col] = 1'b0;
      chk("collummn", i, col, ec);
      chk("flags", i, {1'b0, bsy, rdy, dn}, e.done ? 4'b0011 : 4'b0100);
    end
  endtask

  // Monitor: one expected entry per cycle while a press is outstanding
  always @(negedge clk) begin
    mon(0, col_a, busy_a, ready_a, done_a);
    mon(1, col_b, busy_b, ready_b, done_b);
  end

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [3:0] code, input int wait_cycles);
    key_code  = code;
    key_valid = 1'b1;
    cycles(1);
    key_valid = 1'b0;
    cycles(wait_cycles);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    chk("rst_col", 0, col_a, 4'hF);
    chk("rst_col", 1, col_b, 4'hF);
    chk("rst_busy", 0, {3'b000, busy_a}, 4'b0000);
    chk("rst_busy", 1, {3'b000, busy_b}, 4'b0000);
    qa.delete();
    qb.delete();
    m_rem[0]  = 0;    m_rem[1]  = 0;
    m_lfsr[0] = SEED; m_lfsr[1] = SEED;
    cycles(2);
    rst = 1'b0;
    #1;
    chk("rst_ready", 0, {3'b000, ready_a}, 4'b0001);
    chk("rst_ready", 1, {3'b000, ready_b}, 4'b0001);
  endtask

  initial begin
    logic [3:0] onehot;
    rst = 1'b1; key_valid = 1'b0; key_code = 4'd0; LINE = 4'hF;
    cycles(3);
    rst = 1'b0;
    cycles(2);

    // Key 5 with its row driven
    LINE = 4'b1101;
    send(4'd5, 30);

    // Wrong row, then the right row mid-hold
    LINE = 4'b1011;
    send(4'd5, 4);
    LINE = 4'b1101;
    cycles(26);

    // Key 13, bottom-right, with bounce on dut_b
    LINE = 4'b0111;
    send(4'd13, 30);

    // Request for key 2 while busy must be dropped
    LINE = 4'b1110;
    send(4'd5, 2);
    key_code = 4'd2; key_valid = 1'b1;
    cycles(3);
    key_valid = 1'b0;
    cycles(25);
    send(4'd2, 30);

    // Reset during hold, then a fresh press
    LINE = 4'b1011;
    send(4'd7, 7);
    apply_reset();
    cycles(1);
    send(4'd7, 30);

    // All codes, row drive rotating one-hot low
    for (int code = 0; code < 16; code++) begin
      key_code = 4'(code); key_valid = 1'b1;
      cycles(1);
      key_valid = 1'b0;
      for (int k = 0; k < 26; k++) begin
        onehot = 4'b0001 << ((k + code) % 4);
        LINE = ~onehot;
        cycles(1);
      end
    end

    // Random requests, codes and row drive; the model decides acceptance
    for (int c = 0; c < 800; c++) begin
      key_valid = ($urandom_range(0, 3) == 0);
      key_code  = 4'($urandom_range(0, 15));
      LINE      = 4'($urandom);
      cycles(1);
    end
    key_valid = 1'b0;
    cycles(40);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
